// File: rtl/refresh_timer.sv
// DRAM refresh demand generator: a prescaler raises one obligation per interval,
// obligations accumulate as debt and escalate to urgent by level or by age.
module refresh_timer #(
  parameter int INTERVAL    = 390,
  parameter int URGENT_AGE  = 250,
  parameter int URGENT_DEBT = 2,
  parameter int MAX_DEBT    = 7
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       RefAck,
  output logic       RefReq,
  output logic       RefUrgent,
  output logic       RefOverrun,
  output logic [3:0] RefDebt
);

  localparam int CW = $clog2(INTERVAL);
  localparam int AW = (URGENT_AGE < 1) ? 1 : $clog2(URGENT_AGE + 1);

  localparam logic [CW-1:0] TICK_AT     = CW'(INTERVAL - 1);
  localparam logic [AW-1:0] AGE_LIMIT   = AW'(URGENT_AGE);
  localparam logic [3:0]    DEBT_MAX    = 4'(MAX_DEBT);
  localparam logic [3:0]    DEBT_URGENT = 4'(URGENT_DEBT);

  logic [CW-1:0] cntReg;
  logic [AW-1:0] ageReg;
  logic [3:0]    debtReg;
  logic          ackQReg;
  logic          overrunReg;

  logic tick;
  logic ackRise;

  assign tick    = (cntReg == TICK_AT);
  assign ackRise = RefAck & ~ackQReg;

  // ackQReg resets high so an ack held across reset release is not a completion.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      cntReg     <= '0;
      ageReg     <= '0;
      debtReg    <= '0;
      ackQReg    <= 1'b1;
      overrunReg <= 1'b0;
    end else begin
      ackQReg <= RefAck;
      cntReg  <= tick ? '0 : cntReg + 1'b1;

      // A tick coinciding with a retirement nets to zero and never overruns.
      if (tick && !ackRise) begin
        if (debtReg < DEBT_MAX) begin
          debtReg <= debtReg + 4'd1;
        end else begin
          overrunReg <= 1'b1;
        end
      end else if (!tick && ackRise && (debtReg != 4'd0)) begin
        debtReg <= debtReg - 4'd1;
      end

      if (ackRise || (debtReg == 4'd0)) begin
        ageReg <= '0;
      end else if (ageReg < AGE_LIMIT) begin
        ageReg <= ageReg + 1'b1;
      end
    end
  end

  assign RefReq     = (debtReg != 4'd0);
  assign RefUrgent  = (debtReg >= DEBT_URGENT) ||
                      ((debtReg != 4'd0) && (ageReg >= AGE_LIMIT));
  assign RefOverrun = overrunReg;
  assign RefDebt    = debtReg;

endmodule

// File: tb/tb_refresh_timer.sv
// Directed bench for refresh_timer: an event-time model checked every cycle,
// plus literal expectations at hand-computed edges.
module tb_refresh_timer;

  localparam int INTERVAL    = 8;
  localparam int URGENT_AGE  = 5;
  localparam int URGENT_DEBT = 2;
  localparam int MAX_DEBT    = 3;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       RefAck = 1'b0;
  logic       RefReq;
  logic       RefUrgent;
  logic       RefOverrun;
  logic [3:0] RefDebt;

  int nChecks = 0;
  int nPass   = 0;
  bit started = 1'b0;

  // Model state: edges since release, debt, overrun, and the edge number from
  // which the current obligation's age is measured.
  int mEdge    = 0;
  int mDebt    = 0;
  int mOverrun = 0;
  int mAgeFrom = 0;
  bit mPrevAck = 1'b1;

  refresh_timer #(
    .INTERVAL   (INTERVAL),
    .URGENT_AGE (URGENT_AGE),
    .URGENT_DEBT(URGENT_DEBT),
    .MAX_DEBT   (MAX_DEBT)
  ) dut (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .RefAck    (RefAck),
    .RefReq    (RefReq),
    .RefUrgent (RefUrgent),
    .RefOverrun(RefOverrun),
    .RefDebt   (RefDebt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, act, exp, mEdge, $time);
    end
  endtask

  always @(posedge CLK) begin
    bit tickNow;
    bit riseNow;
    started = 1'b1;
    if (!nRESET) begin
      mEdge    = 0;
      mDebt    = 0;
      mOverrun = 0;
      mAgeFrom = 0;
      mPrevAck = 1'b1;
    end else begin
      mEdge++;
      tickNow  = ((mEdge % INTERVAL) == 0);
      riseNow  = RefAck && !mPrevAck;
      mPrevAck = RefAck;
      if (riseNow || mDebt == 0) mAgeFrom = mEdge;
      if (tickNow && !riseNow) begin
        if (mDebt < MAX_DEBT) mDebt++;
        else mOverrun = 1;
      end else if (riseNow && !tickNow && mDebt > 0) begin
        mDebt--;
      end
    end
  end

  always @(negedge CLK) begin
    int expUrg;
    if (started) begin
      expUrg = ((mDebt >= URGENT_DEBT) ||
                (mDebt != 0 && (mEdge - mAgeFrom) >= URGENT_AGE)) ? 1 : 0;
      check("model_RefReq", int'(RefReq), (mDebt != 0) ? 1 : 0);
      check("model_RefUrgent", int'(RefUrgent), expUrg);
      check("model_RefOverrun", int'(RefOverrun), mOverrun);
      check("model_RefDebt", int'(RefDebt), mDebt);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic doReset(input bit ackLevel);
    RefAck = ackLevel;
    nRESET = 1'b0;
    step(2);
    nRESET = 1'b1;
  endtask

  initial begin
    // Scenario 1 + 3: free-running debt climb, urgency by age then level, overrun.
    doReset(1'b0);
    step(7);
    check("s1_req_edge7", int'(RefReq), 0);
    step(1);
    check("s1_req_edge8", int'(RefReq), 1);
    check("s1_debt_edge8", int'(RefDebt), 1);
    step(4);
    check("s1_urg_edge12", int'(RefUrgent), 0);
    step(1);
    check("s1_urg_edge13", int'(RefUrgent), 1);
    step(3);
    check("s1_debt_edge16", int'(RefDebt), 2);
    step(8);
    check("s3_debt_edge24", int'(RefDebt), 3);
    step(7);
    check("s3_ovr_edge31", int'(RefOverrun), 0);
    step(1);
    check("s3_debt_edge32", int'(RefDebt), 3);
    check("s3_ovr_edge32", int'(RefOverrun), 1);
    step(8);
    check("s3_ovr_edge40", int'(RefOverrun), 1);
    $display("scenario 1/3: debt climb and overrun done");

    // Scenario 2: ack pulses retire exactly one obligation each.
    doReset(1'b0);
    step(8);
    RefAck = 1'b1;
    step(1);
    check("s2_debt_ack", int'(RefDebt), 0);
    check("s2_req_ack", int'(RefReq), 0);
    check("s2_urg_ack", int'(RefUrgent), 0);
    step(1);
    RefAck = 1'b0;
    step(14);
    check("s2_debt_edge24", int'(RefDebt), 2);
    RefAck = 1'b1;
    step(3);
    check("s2_debt_long_ack", int'(RefDebt), 1);
    RefAck = 1'b0;
    step(1);
    $display("scenario 2: single retirement per ack pulse done");

    // Scenario 4: ack rise on a tick at saturation nets zero without overrun.
    doReset(1'b0);
    step(24);
    check("s4_debt_edge24", int'(RefDebt), 3);
    step(7);
    RefAck = 1'b1;
    step(1);
    check("s4_debt_tick_ack", int'(RefDebt), 3);
    check("s4_ovr_tick_ack", int'(RefOverrun), 0);
    step(1);
    RefAck = 1'b0;
    step(1);
    check("s4_debt_after", int'(RefDebt), 3);
    $display("scenario 4: coincident tick and ack done");

    // Scenario 5: ack held across reset release is not a completion.
    doReset(1'b1);
    step(8);
    check("s5_debt_edge8", int'(RefDebt), 1);
    RefAck = 1'b0;
    step(1);
    RefAck = 1'b1;
    step(1);
    check("s5_debt_reraise", int'(RefDebt), 0);
    step(1);
    RefAck = 1'b0;
    step(1);
    $display("scenario 5: ack held through reset done");

    // Scenario 6: mid-interval reset discards debt and overrun, prescaler restarts.
    doReset(1'b0);
    step(32);
    RefAck = 1'b1;
    step(1);
    check("s6_debt_pre", int'(RefDebt), 2);
    step(1);
    RefAck = 1'b0;
    check("s6_ovr_pre", int'(RefOverrun), 1);
    nRESET = 1'b0;
    step(1);
    nRESET = 1'b1;
    check("s6_req_rst", int'(RefReq), 0);
    check("s6_ovr_rst", int'(RefOverrun), 0);
    check("s6_debt_rst", int'(RefDebt), 0);
    step(7);
    check("s6_req_edge7", int'(RefReq), 0);
    step(1);
    check("s6_req_edge8", int'(RefReq), 1);
    $display("scenario 6: mid-operation reset done");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
